// File: rtl/cordic_channel_arbiter.sv
// Round-robin front end that shares one fixed-latency CORDIC core between N_CH angle
// requesters, tracking each issued angle's channel so results come back labelled.
module cordic_channel_arbiter #(
   parameter int N_CH            = 4,
   parameter int INT_ANGLE_WIDTH = 32,
   parameter int INT_DATA_WIDTH  = 20,
   parameter int CORDIC_LATENCY  = 31,
   localparam int CH_W           = $clog2(N_CH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_CH-1:0]                i_ch_enable,
   input  logic [N_CH-1:0]                i_req_valid,
   input  logic [N_CH*INT_ANGLE_WIDTH-1:0] i_req_angle,
   output logic [N_CH-1:0]                o_req_ready,
   output logic                           o_cordic_valid,
   output logic [INT_ANGLE_WIDTH-1:0]     o_cordic_angle,
   input  logic                           i_cordic_valid,
   input  logic [INT_DATA_WIDTH:0]        i_cordic_cos,
   input  logic [INT_DATA_WIDTH:0]        i_cordic_sin,
   output logic                           o_valid,
   output logic [CH_W-1:0]                o_ch,
   output logic [INT_DATA_WIDTH:0]        o_cos,
   output logic [INT_DATA_WIDTH:0]        o_sin,
   output logic                           o_busy,
   output logic                           o_err
);

   localparam int AW  = INT_ANGLE_WIDTH;
   localparam int DW  = INT_DATA_WIDTH + 1;
   localparam int LAT = CORDIC_LATENCY;
   localparam int CW1 = CH_W + 1;
   localparam int FW  = $clog2(CORDIC_LATENCY + 1);
   localparam logic [FW-1:0]   FLUSH_LOAD = FW'(CORDIC_LATENCY);
   localparam logic [CH_W-1:0] LAST_CH    = CH_W'(N_CH - 1);

   logic [FW-1:0]             flush_cnt_q, flush_cnt_d;
   logic                      flush_s;
   logic [N_CH-1:0]           eligible_s;
   logic [N_CH-1:0]           ready_s;
   logic                      grant_vld_s;
   logic [CH_W-1:0]           grant_idx_s;
   logic [CW1-1:0]            scan_s;
   logic [CH_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic                      cvalid_q, cvalid_d;
   logic [AW-1:0]             cangle_q, cangle_d;
   logic [CH_W-1:0]           issue_ch_q, issue_ch_d;
   logic [LAT-1:0]            tag_vld_q, tag_vld_d;
   logic [LAT-1:0][CH_W-1:0]  tag_ch_q, tag_ch_d;
   logic                      tail_vld_s;
   logic [CH_W-1:0]           tail_ch_s;
   logic                      valid_q, valid_d;
   logic [CH_W-1:0]           ch_q, ch_d;
   logic [DW-1:0]             cos_q, cos_d;
   logic [DW-1:0]             sin_q, sin_d;
   logic                      err_q, err_d;

   // The core cannot be reset, so stale results are discarded for one full latency.
   assign flush_s = (flush_cnt_q != {FW{1'b0}});

   always_comb begin
      if (flush_s) begin
         flush_cnt_d = flush_cnt_q - FW'(1);
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Grant is held off during reset as well, so nothing is handed out that cannot issue.
   always_comb begin
      eligible_s  = i_req_valid & i_ch_enable & {N_CH{~flush_s}} & {N_CH{~rst}};
      grant_vld_s = 1'b0;
      grant_idx_s = rr_ptr_q;
      scan_s      = {CW1{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
         scan_s = CW1'(rr_ptr_q) + CW1'(k);
         if (scan_s >= CW1'(N_CH)) begin
            scan_s = scan_s - CW1'(N_CH);
         end else begin
            scan_s = scan_s;
         end
         if (!grant_vld_s && eligible_s[scan_s[CH_W-1:0]]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = scan_s[CH_W-1:0];
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
      ready_s = {N_CH{1'b0}};
      if (grant_vld_s) begin
         ready_s[grant_idx_s] = 1'b1;
      end else begin
         ready_s = {N_CH{1'b0}};
      end
   end

   always_comb begin
      if (grant_vld_s) begin
         rr_ptr_d   = (grant_idx_s == LAST_CH) ? {CH_W{1'b0}} : grant_idx_s + CH_W'(1);
         cangle_d   = i_req_angle[grant_idx_s*AW +: AW];
         issue_ch_d = grant_idx_s;
      end else begin
         rr_ptr_d   = rr_ptr_q;
         cangle_d   = cangle_q;
         issue_ch_d = issue_ch_q;
      end
      cvalid_d = grant_vld_s;
   end

   always_comb begin
      tag_vld_d[0] = cvalid_q;
      tag_ch_d[0]  = issue_ch_q;
      for (int i = 1; i < LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_ch_d[i]  = tag_ch_q[i-1];
      end
   end

   assign tail_vld_s = tag_vld_q[LAT-1];
   assign tail_ch_s  = tag_ch_q[LAT-1];

   // A result is only accepted when the core strobe and the expected tag agree.
   always_comb begin
      valid_d = i_cordic_valid & tail_vld_s & ~flush_s;
      if (valid_d) begin
         ch_d  = tail_ch_s;
         cos_d = i_cordic_cos;
         sin_d = i_cordic_sin;
      end else begin
         ch_d  = ch_q;
         cos_d = cos_q;
         sin_d = sin_q;
      end
      err_d = err_q | (~flush_s & (i_cordic_valid ^ tail_vld_s));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt_q <= FLUSH_LOAD;
         rr_ptr_q    <= {CH_W{1'b0}};
         cvalid_q    <= 1'b0;
         cangle_q    <= {AW{1'b0}};
         issue_ch_q  <= {CH_W{1'b0}};
         tag_vld_q   <= {LAT{1'b0}};
         tag_ch_q    <= {(LAT*CH_W){1'b0}};
         valid_q     <= 1'b0;
         ch_q        <= {CH_W{1'b0}};
         cos_q       <= {DW{1'b0}};
         sin_q       <= {DW{1'b0}};
         err_q       <= 1'b0;
      end else begin
         flush_cnt_q <= flush_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         cvalid_q    <= cvalid_d;
         cangle_q    <= cangle_d;
         issue_ch_q  <= issue_ch_d;
         tag_vld_q   <= tag_vld_d;
         tag_ch_q    <= tag_ch_d;
         valid_q     <= valid_d;
         ch_q        <= ch_d;
         cos_q       <= cos_d;
         sin_q       <= sin_d;
         err_q       <= err_d;
      end
   end

   assign o_req_ready    = ready_s;
   assign o_cordic_valid = cvalid_q;
   assign o_cordic_angle = cangle_q;
   assign o_valid        = valid_q;
   assign o_ch           = ch_q;
   assign o_cos          = cos_q;
   assign o_sin          = sin_q;
   assign o_err          = err_q;
   assign o_busy         = flush_s | cvalid_q | (|tag_vld_q);

endmodule

// File: tb/tb_cordic_channel_arbiter.sv
// Randomised bench for cordic_channel_arbiter: a fixed-delay core stand-in, a transaction-level
// reference of the arbiter, and a scoreboard drained by an independent monitor process.
module tb_cordic_channel_arbiter;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int IDW = 20;
   localparam int DW  = IDW + 1;
   localparam int L   = 31;
   localparam int CHW = 2;
   localparam int HIST = 4096;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     en  = '0;
   logic [N-1:0]     vld = '0;
   logic [N*AW-1:0]  ang = '0;
   logic             inj = 1'b0;
   logic [N-1:0]     o_req_ready;
   logic             o_cordic_valid;
   logic [AW-1:0]    o_cordic_angle;
   logic             i_cordic_valid;
   logic [DW-1:0]    i_cordic_cos, i_cordic_sin;
   logic             o_valid, o_busy, o_err;
   logic [CHW-1:0]   o_ch;
   logic [DW-1:0]    o_cos, o_sin;

   always #5 clk = ~clk;

   cordic_channel_arbiter #(.N_CH(N), .INT_ANGLE_WIDTH(AW), .INT_DATA_WIDTH(IDW),
                            .CORDIC_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .i_ch_enable(en), .i_req_valid(vld), .i_req_angle(ang),
      .o_req_ready(o_req_ready), .o_cordic_valid(o_cordic_valid), .o_cordic_angle(o_cordic_angle),
      .i_cordic_valid(i_cordic_valid), .i_cordic_cos(i_cordic_cos), .i_cordic_sin(i_cordic_sin),
      .o_valid(o_valid), .o_ch(o_ch), .o_cos(o_cos), .o_sin(o_sin), .o_busy(o_busy), .o_err(o_err));

   function automatic logic [DW-1:0] core_cos(input logic [AW-1:0] a);
      return a[AW-1:AW-DW];
   endfunction

   function automatic logic [DW-1:0] core_sin(input logic [AW-1:0] a);
      return a[DW-1:0] ^ 21'h15555;
   endfunction

   // Core stand-in: pure delay line with no reset, plus an injectable spurious strobe.
   logic [L-1:0]  core_v = '0;
   logic [AW-1:0] core_a [L];
   always @(posedge clk) begin
      core_v    <= {core_v[L-2:0], o_cordic_valid};
      core_a[0] <= o_cordic_angle;
      for (int i = 1; i < L; i++) core_a[i] <= core_a[i-1];
   end
   assign i_cordic_valid = core_v[L-1] | inj;
   assign i_cordic_cos   = core_cos(core_a[L-1]);
   assign i_cordic_sin   = core_sin(core_a[L-1]);

   typedef struct {
      int            ch;
      logic [AW-1:0] angle;
      int            due;
   } exp_t;
   exp_t sb[$];

   int           checks = 0, errors = 0;
   int           cyc = 0;
   int           m_ptr = 0, m_cnt = 0;
   bit           m_err = 0, m_cv = 0, model_ok = 0;
   logic [AW-1:0] m_cang = '0;
   bit           acc_hist [HIST];
   logic [N-1:0] exp_ready = '0;
   bit           exp_err = 0, exp_busy = 0, cur_rst = 1;
   bit           p_rst = 0, p_grant = 0, p_flush = 0, p_inj = 0, p_tail = 0;
   int           p_g = 0;
   logic [AW-1:0] p_ang = '0;

   function automatic bit accepted(input int c);
      if (c < 0 || c >= HIST) return 1'b0;
      return acc_hist[c];
   endfunction

   // One clock of stimulus: advance the reference across the edge, then drive and predict.
   task automatic step(input bit r, input logic [N-1:0] e, input logic [N-1:0] v,
                       input logic [N*AW-1:0] a, input bit j);
      bit flush;
      int g;
      logic [N-1:0] elig;
      @(posedge clk); #1;
      cyc++;
      if (p_rst) begin
         m_ptr = 0; m_cnt = L; m_err = 0; m_cv = 0; m_cang = '0; model_ok = 1;
      end else begin
         if (!p_flush && p_inj && !p_tail) m_err = 1;
         if (p_grant) begin
            m_ptr  = (p_g + 1) % N;
            m_cang = p_ang;
         end
         m_cv = p_grant;
         if (m_cnt > 0) m_cnt--;
      end
      rst = r; en = e; vld = v; ang = a; inj = j;
      flush = (m_cnt != 0);
      elig  = (flush || r) ? '0 : (v & e);
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_ready = '0;
      if (g >= 0) begin
         exp_ready[g] = 1'b1;
         sb.push_back('{g, a[g*AW +: AW], cyc + L + 2});
         if (cyc < HIST) acc_hist[cyc] = 1'b1;
      end
      if (r) while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      exp_busy = flush || m_cv;
      for (int d = 2; d <= L + 1; d++) if (accepted(cyc - d)) exp_busy = 1;
      exp_err = m_err;
      cur_rst = r;
      p_rst = r; p_grant = (g >= 0); p_g = g; p_flush = flush; p_inj = j;
      p_ang = (g >= 0) ? a[g*AW +: AW] : '0;
      p_tail = accepted(cyc - L - 1);
   endtask

   function automatic logic [N*AW-1:0] rnd_ang();
      logic [N*AW-1:0] r;
      for (int k = 0; k < N; k++) r[k*AW +: AW] = $urandom();
      return r;
   endfunction

   // Monitor: compares DUT outputs with the reference mid-cycle and drains the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (model_ok) begin
            checks++;
            if (o_req_ready !== exp_ready) begin
               errors++;
               $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, o_req_ready, exp_ready);
            end
            checks++;
            if (o_cordic_valid !== m_cv || o_cordic_angle !== m_cang) begin
               errors++;
               $display("FAIL issue cyc=%0d got=%b/%h exp=%b/%h", cyc, o_cordic_valid,
                        o_cordic_angle, m_cv, m_cang);
            end
            if (!cur_rst) begin
               checks++;
               if (o_err !== exp_err || o_busy !== exp_busy) begin
                  errors++;
                  $display("FAIL err_busy cyc=%0d got=%b/%b exp=%b/%b", cyc, o_err, o_busy,
                           exp_err, exp_busy);
               end
            end
            if (o_valid) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_result cyc=%0d ch=%0d got=1 exp=0", cyc, o_ch);
               end else begin
                  e = sb.pop_front();
                  if (o_ch !== e.ch[CHW-1:0] || o_cos !== core_cos(e.angle) ||
                      o_sin !== core_sin(e.angle) || e.due != cyc) begin
                     errors++;
                     $display("FAIL result cyc=%0d got ch=%0d cos=%h sin=%h exp ch=%0d cos=%h sin=%h due=%0d",
                              cyc, o_ch, o_cos, o_sin, e.ch, core_cos(e.angle),
                              core_sin(e.angle), e.due);
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [N*AW-1:0] a;
      repeat (3) step(1, '0, '0, '0, 0);
      // Channel 2 requests throughout flush; first grant lands right after it.
      a = rnd_ang();
      a[2*AW +: AW] = 32'h4000_0000;
      repeat (L + 1) step(0, 4'hF, 4'b0100, a, 0);
      repeat (40) step(0, 4'hF, 4'b0000, rnd_ang(), 0);
      repeat (40) step(0, 4'hF, 4'hF, rnd_ang(), 0);
      repeat (12) step(0, 4'hF, 4'b1010, rnd_ang(), 0);
      repeat (40) step(0, 4'b1011, N'($urandom), rnd_ang(), 0);
      repeat (200) step(0, N'($urandom), N'($urandom), rnd_ang(), 0);
      repeat (L + 5) step(0, 4'hF, 4'b0000, rnd_ang(), 0);
      // Spurious core strobe on an empty tail, then normal traffic with the flag held.
      step(0, 4'hF, 4'b0000, rnd_ang(), 1);
      repeat (5) step(0, 4'hF, 4'b0000, rnd_ang(), 0);
      repeat (20) step(0, 4'hF, 4'hF, rnd_ang(), 0);
      // Reset with results in flight; stray strobes during flush must be ignored.
      repeat (10) step(0, 4'hF, 4'hF, rnd_ang(), 0);
      repeat (2) step(1, 4'hF, 4'hF, rnd_ang(), 0);
      for (int i = 0; i < L; i++) step(0, 4'hF, 4'hF, rnd_ang(), (i % 7) == 3);
      repeat (30) step(0, 4'hF, N'($urandom), rnd_ang(), 0);
      repeat (L + 5) step(0, 4'hF, 4'b0000, rnd_ang(), 0);
      @(negedge clk); #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending exp=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
